// File: rtl/exwb_pkg.sv
// Shared types and constants for the execute/write-back back end.
// Optional divider is selected with the EXWB_DIV_EN macro (see execute_write_back).
package exwb_pkg;

    localparam int unsigned DataW    = 16;
    localparam int unsigned TagW     = 3;
    localparam int unsigned RegW     = 4;
    localparam int unsigned RobDepth = 8;
    localparam int unsigned RsDepth  = 4;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpMul = 4'd2,
        OpDiv = 4'd3
    } op_e;

    typedef struct packed {
        logic             busy;
        op_e              op;
        logic             q1_rdy;
        logic [DataW-1:0] v1;
        logic             q2_rdy;
        logic [DataW-1:0] v2;
        logic [TagW-1:0]  dest_tag;
    } rs_entry_t;

    typedef struct packed {
        op_e              op;
        logic [RegW-1:0]  dest;
        logic             done;
        logic [DataW-1:0] value;
    } rob_entry_t;

    function automatic logic op_legal(logic [3:0] op);
        return op <= 4'd3;
    endfunction

    function automatic logic op_is_rs2(logic [3:0] op);
        return (op == OpMul) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/exwb_rs.sv
// Reservation station: entry array, lowest-index allocate/select, result-bus wakeup.
module exwb_rs
    import exwb_pkg::*;
#(
    parameter int unsigned DEPTH = RsDepth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  rs_entry_t        alloc_entry,
    input  logic             wake1_valid,
    input  logic [TagW-1:0]  wake1_tag,
    input  logic [DataW-1:0] wake1_value,
    input  logic             wake2_valid,
    input  logic [TagW-1:0]  wake2_tag,
    input  logic [DataW-1:0] wake2_value,
    output logic             full,
    output logic             sel_valid,
    output op_e              sel_op,
    output logic [DataW-1:0] sel_a,
    output logic [DataW-1:0] sel_b,
    output logic [TagW-1:0]  sel_tag
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t       entries_q [DEPTH];
    rs_entry_t       entries_d [DEPTH];
    logic [IdxW-1:0] alloc_idx;
    logic [IdxW-1:0] sel_idx;

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        full      = 1'b1;
        alloc_idx = '0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!entries_q[i].busy) begin
                full      = 1'b0;
                alloc_idx = IdxW'(i);
            end else if (entries_q[i].q1_rdy && entries_q[i].q2_rdy) begin
                sel_valid = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    always_comb begin
        sel_op  = entries_q[sel_idx].op;
        sel_a   = entries_q[sel_idx].v1;
        sel_b   = entries_q[sel_idx].v2;
        sel_tag = entries_q[sel_idx].dest_tag;
    end

    // Waiting operands hold their tag in the low bits of the value field.
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entries_d[i].busy && !entries_d[i].q1_rdy) begin
                if (wake1_valid && entries_d[i].v1[TagW-1:0] == wake1_tag) begin
                    entries_d[i].v1     = wake1_value;
                    entries_d[i].q1_rdy = 1'b1;
                end else if (wake2_valid && entries_d[i].v1[TagW-1:0] == wake2_tag) begin
                    entries_d[i].v1     = wake2_value;
                    entries_d[i].q1_rdy = 1'b1;
                end
            end
            if (entries_d[i].busy && !entries_d[i].q2_rdy) begin
                if (wake1_valid && entries_d[i].v2[TagW-1:0] == wake1_tag) begin
                    entries_d[i].v2     = wake1_value;
                    entries_d[i].q2_rdy = 1'b1;
                end else if (wake2_valid && entries_d[i].v2[TagW-1:0] == wake2_tag) begin
                    entries_d[i].v2     = wake2_value;
                    entries_d[i].q2_rdy = 1'b1;
                end
            end
            if (sel_valid && sel_idx == IdxW'(i)) begin
                entries_d[i].busy = 1'b0;
            end
            if (alloc_valid && !full && alloc_idx == IdxW'(i)) begin
                entries_d[i] = alloc_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= rst ? '0 : entries_d[i];
        end
    end

endmodule

// File: rtl/execute_write_back.sv
// Tomasulo back end: two reservation stations, two single-cycle FUs, 8-entry ROB, in-order commit.
// Define EXWB_DIV_EN to make opcode 3 an unsigned divide; otherwise opcode 3 is bitwise AND.
module execute_write_back
    import exwb_pkg::*;
#(
    parameter int unsigned DATA_W    = DataW,
    parameter int unsigned RS_DEPTH  = RsDepth,
    parameter int unsigned ROB_DEPTH = RobDepth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    input  logic [3:0]        disp_op,
    input  logic [3:0]        disp_dest,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    input  logic [DATA_W-1:0] disp_src1,
    input  logic [DATA_W-1:0] disp_src2,
    output logic              disp_accept,
    output logic [2:0]        disp_tag,
    output logic              rob_full,
    output logic              rs1_full,
    output logic              rs2_full,
    output logic [3:0]        rob_count,
    output logic              cdb1_valid,
    output logic [2:0]        cdb1_tag,
    output logic [DATA_W-1:0] cdb1_value,
    output logic              cdb2_valid,
    output logic [2:0]        cdb2_tag,
    output logic [DATA_W-1:0] cdb2_value,
    output logic              commit_valid,
    output logic [3:0]        commit_reg,
    output logic [2:0]        commit_tag,
    output logic [DATA_W-1:0] commit_value
);

    rob_entry_t       rob_q [ROB_DEPTH];
    rob_entry_t       rob_d [ROB_DEPTH];
    logic [TagW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [3:0]       count_q, count_d;

    logic             to_rs2, rs1_alloc, rs2_alloc, commit_fire;
    logic [DataW:0]   cap1, cap2;
    rs_entry_t        alloc_entry;

    logic             sel1_valid, sel2_valid;
    op_e              sel1_op, sel2_op;
    logic [DataW-1:0] sel1_a, sel1_b, sel2_a, sel2_b;
    logic [TagW-1:0]  sel1_tag, sel2_tag;
    logic [DataW-1:0] res1, res2, prod, quot;

    // Returns {ready, value}; results landing this edge take priority over the ROB.
    function automatic logic [DataW:0] capture(
        logic rdy, logic [DataW-1:0] src,
        logic r1v, logic [TagW-1:0] r1t, logic [DataW-1:0] r1d,
        logic r2v, logic [TagW-1:0] r2t, logic [DataW-1:0] r2d,
        logic rob_done, logic [DataW-1:0] rob_value);
        logic [TagW-1:0] tag;
        tag = src[TagW-1:0];
        if (rdy)                   return {1'b1, src};
        if (r1v && r1t == tag)     return {1'b1, r1d};
        if (r2v && r2t == tag)     return {1'b1, r2d};
        if (rob_done)              return {1'b1, rob_value};
        return {1'b0, src};
    endfunction

    always_comb begin
        rob_full    = (count_q == 4'(ROB_DEPTH));
        rob_count   = count_q;
        disp_tag    = tail_q;
        to_rs2      = op_is_rs2(disp_op);
        disp_accept = disp_valid && op_legal(disp_op) && !rob_full &&
                      !(to_rs2 ? rs2_full : rs1_full);
        rs1_alloc   = disp_accept && !to_rs2;
        rs2_alloc   = disp_accept && to_rs2;
    end

    always_comb begin
        cap1 = capture(disp_src1_rdy, disp_src1, sel1_valid, sel1_tag, res1,
                       sel2_valid, sel2_tag, res2,
                       rob_q[disp_src1[TagW-1:0]].done, rob_q[disp_src1[TagW-1:0]].value);
        cap2 = capture(disp_src2_rdy, disp_src2, sel1_valid, sel1_tag, res1,
                       sel2_valid, sel2_tag, res2,
                       rob_q[disp_src2[TagW-1:0]].done, rob_q[disp_src2[TagW-1:0]].value);
        alloc_entry.busy     = 1'b1;
        alloc_entry.op       = op_e'(disp_op);
        alloc_entry.q1_rdy   = cap1[DataW];
        alloc_entry.v1       = cap1[DataW-1:0];
        alloc_entry.q2_rdy   = cap2[DataW];
        alloc_entry.v2       = cap2[DataW-1:0];
        alloc_entry.dest_tag = tail_q;
    end

    exwb_rs #(.DEPTH(RS_DEPTH)) u_rs1 (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (rs1_alloc),
        .alloc_entry (alloc_entry),
        .wake1_valid (sel1_valid),
        .wake1_tag   (sel1_tag),
        .wake1_value (res1),
        .wake2_valid (sel2_valid),
        .wake2_tag   (sel2_tag),
        .wake2_value (res2),
        .full        (rs1_full),
        .sel_valid   (sel1_valid),
        .sel_op      (sel1_op),
        .sel_a       (sel1_a),
        .sel_b       (sel1_b),
        .sel_tag     (sel1_tag)
    );

    exwb_rs #(.DEPTH(RS_DEPTH)) u_rs2 (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (rs2_alloc),
        .alloc_entry (alloc_entry),
        .wake1_valid (sel1_valid),
        .wake1_tag   (sel1_tag),
        .wake1_value (res1),
        .wake2_valid (sel2_valid),
        .wake2_tag   (sel2_tag),
        .wake2_value (res2),
        .full        (rs2_full),
        .sel_valid   (sel2_valid),
        .sel_op      (sel2_op),
        .sel_a       (sel2_a),
        .sel_b       (sel2_b),
        .sel_tag     (sel2_tag)
    );

    always_comb begin
        res1 = (sel1_op == OpSub) ? sel1_a - sel1_b : sel1_a + sel1_b;
        prod = sel2_a * sel2_b;
`ifdef EXWB_DIV_EN
        quot = (sel2_b == '0) ? '1 : sel2_a / sel2_b;
`else
        quot = sel2_a & sel2_b;
`endif
        res2 = (sel2_op == OpMul) ? prod : quot;
    end

    // Done bits survive commit, so an empty ROB must never look committable.
    assign commit_fire = (count_q != '0) && rob_q[head_q].done;

    always_comb begin
        rob_d  = rob_q;
        head_d = head_q;
        tail_d = tail_q;
        if (disp_accept) begin
            rob_d[tail_q] = '{op: op_e'(disp_op), dest: disp_dest, done: 1'b0, value: '0};
            tail_d        = tail_q + 1'b1;
        end
        if (sel1_valid) begin
            rob_d[sel1_tag].value = res1;
            rob_d[sel1_tag].done  = 1'b1;
        end
        if (sel2_valid) begin
            rob_d[sel2_tag].value = res2;
            rob_d[sel2_tag].done  = 1'b1;
        end
        if (commit_fire) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + 4'(disp_accept) - 4'(commit_fire);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(ROB_DEPTH); i++) begin
            rob_q[i] <= rst ? '0 : rob_d[i];
        end
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            cdb1_valid   <= 1'b0;
            cdb1_tag     <= '0;
            cdb1_value   <= '0;
            cdb2_valid   <= 1'b0;
            cdb2_tag     <= '0;
            cdb2_value   <= '0;
            commit_valid <= 1'b0;
            commit_reg   <= '0;
            commit_tag   <= '0;
            commit_value <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            cdb1_valid   <= sel1_valid;
            cdb1_tag     <= sel1_tag;
            cdb1_value   <= res1;
            cdb2_valid   <= sel2_valid;
            cdb2_tag     <= sel2_tag;
            cdb2_value   <= res2;
            commit_valid <= commit_fire;
            if (commit_fire) begin
                commit_reg   <= rob_q[head_q].dest;
                commit_tag   <= head_q;
                commit_value <= rob_q[head_q].value;
            end
        end
    end

endmodule

// File: tb/tb_execute_write_back.sv
// Self-checking bench for execute_write_back: directed scenarios plus a randomized program
// checked against an in-order program-level model of the committed results.
module tb_execute_write_back;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_valid = 1'b0;
    logic [3:0]  disp_op = '0, disp_dest = '0;
    logic        disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic [15:0] disp_src1 = '0, disp_src2 = '0;
    logic        disp_accept, rob_full, rs1_full, rs2_full;
    logic [2:0]  disp_tag;
    logic [3:0]  rob_count;
    logic        cdb1_valid, cdb2_valid, commit_valid;
    logic [2:0]  cdb1_tag, cdb2_tag, commit_tag;
    logic [15:0] cdb1_value, cdb2_value, commit_value;
    logic [3:0]  commit_reg;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  dest;
        logic [2:0]  tag;
        logic [15:0] val;
    } exp_t;

    execute_write_back dut (
        .clk           (clk),
        .rst           (rst),
        .disp_valid    (disp_valid),
        .disp_op       (disp_op),
        .disp_dest     (disp_dest),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src1     (disp_src1),
        .disp_src2     (disp_src2),
        .disp_accept   (disp_accept),
        .disp_tag      (disp_tag),
        .rob_full      (rob_full),
        .rs1_full      (rs1_full),
        .rs2_full      (rs2_full),
        .rob_count     (rob_count),
        .cdb1_valid    (cdb1_valid),
        .cdb1_tag      (cdb1_tag),
        .cdb1_value    (cdb1_value),
        .cdb2_valid    (cdb2_valid),
        .cdb2_tag      (cdb2_tag),
        .cdb2_value    (cdb2_value),
        .commit_valid  (commit_valid),
        .commit_reg    (commit_reg),
        .commit_tag    (commit_tag),
        .commit_value  (commit_value)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] ref_op(int op, longint a, longint b);
        case (op)
            0: return 16'((a + b) % 65536);
            1: return 16'((a - b + 65536) % 65536);
            2: return 16'((a * b) % 65536);
`ifdef EXWB_DIV_EN
            default: return (b == 0) ? 16'hFFFF : 16'(a / b);
`else
            default: return 16'(a & b);
`endif
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int dest, input logic r1, input int s1,
                         input logic r2, input int s2);
        disp_valid    = 1'b1;
        disp_op       = 4'(op);
        disp_dest     = 4'(dest);
        disp_src1_rdy = r1;
        disp_src1     = 16'(s1);
        disp_src2_rdy = r2;
        disp_src2     = 16'(s2);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({disp_accept, disp_tag, rob_full, rs1_full, rs2_full} !== '0)
            $display("FAIL reset_flags: got %b want 0",
                     {disp_accept, disp_tag, rob_full, rs1_full, rs2_full});
        else n_pass++;
        n_checks++;
        if (rob_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", rob_count);
        else n_pass++;
        n_checks++;
        if ({cdb1_valid, cdb1_tag, cdb1_value, cdb2_valid, cdb2_tag, cdb2_value} !== '0)
            $display("FAIL reset_cdb: got nonzero cdb outputs, want 0");
        else n_pass++;
        n_checks++;
        if ({commit_valid, commit_reg, commit_tag, commit_value} !== '0)
            $display("FAIL reset_commit: got %h want 0",
                     {commit_valid, commit_reg, commit_tag, commit_value});
        else n_pass++;
    endtask

    task automatic test_independent_add();
        do_reset();
        drive(0, 3, 1'b1, 5, 1'b1, 7);
        n_checks++;
        if ({disp_accept, disp_tag} !== {1'b1, 3'd0})
            $display("FAIL add_accept: got %b/%0d want 1/0", disp_accept, disp_tag);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (cdb1_valid !== 1'b0) $display("FAIL add_cdb_early: got %b want 0", cdb1_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({cdb1_valid, cdb1_tag, cdb1_value, commit_valid} !== {1'b1, 3'd0, 16'd12, 1'b0})
            $display("FAIL add_cdb: got v%b t%0d %0d c%b want v1 t0 12 c0",
                     cdb1_valid, cdb1_tag, cdb1_value, commit_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_valid, commit_reg, commit_tag, commit_value, cdb1_valid} !==
            {1'b1, 4'd3, 3'd0, 16'd12, 1'b0})
            $display("FAIL add_commit: got v%b r%0d t%0d %0d cdb%b want v1 r3 t0 12 cdb0",
                     commit_valid, commit_reg, commit_tag, commit_value, cdb1_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_valid, rob_count} !== {1'b0, 4'd0})
            $display("FAIL add_pulse: got v%b cnt%0d want v0 cnt0", commit_valid, rob_count);
        else n_pass++;
    endtask

    task automatic test_dependency();
        do_reset();
        drive(2, 1, 1'b1, 3, 1'b1, 4);
        tick();
        drive(0, 2, 1'b0, 0, 1'b1, 1);
        n_checks++;
        if ({disp_accept, disp_tag} !== {1'b1, 3'd1})
            $display("FAIL dep_accept: got %b/%0d want 1/1", disp_accept, disp_tag);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if ({cdb2_valid, cdb2_tag, cdb2_value, cdb1_valid} !== {1'b1, 3'd0, 16'd12, 1'b0})
            $display("FAIL dep_cdb2: got v%b t%0d %0d cdb1 %b want v1 t0 12 cdb1 0",
                     cdb2_valid, cdb2_tag, cdb2_value, cdb1_valid);
        else n_pass++;
        tick();
        n_checks++;
        if ({cdb1_valid, cdb1_tag, cdb1_value} !== {1'b1, 3'd1, 16'd13})
            $display("FAIL dep_cdb1: got v%b t%0d %0d want v1 t1 13",
                     cdb1_valid, cdb1_tag, cdb1_value);
        else n_pass++;
        n_checks++;
        if ({commit_valid, commit_reg, commit_value} !== {1'b1, 4'd1, 16'd12})
            $display("FAIL dep_commit0: got v%b r%0d %0d want v1 r1 12",
                     commit_valid, commit_reg, commit_value);
        else n_pass++;
        tick();
        n_checks++;
        if ({commit_valid, commit_reg, commit_tag, commit_value} !==
            {1'b1, 4'd2, 3'd1, 16'd13})
            $display("FAIL dep_commit1: got v%b r%0d t%0d %0d want v1 r2 t1 13",
                     commit_valid, commit_reg, commit_tag, commit_value);
        else n_pass++;
    endtask

    task automatic test_rs_full();
        do_reset();
        drive(3, 4, 1'b0, 7, 1'b1, 2);  // waits on a tag that is never produced
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 1'b0, 0, 1'b1, i);
            n_checks++;
            if (disp_accept !== 1'b1) $display("FAIL rsfull_sub%0d: got %b want 1", i, disp_accept);
            else n_pass++;
            tick();
        end
        idle();
        n_checks++;
        if ({rs1_full, rs2_full, rob_count} !== {1'b1, 1'b0, 4'd5})
            $display("FAIL rsfull_flags: got rs1 %b rs2 %b cnt %0d want 1 0 5",
                     rs1_full, rs2_full, rob_count);
        else n_pass++;
        drive(1, 5, 1'b0, 0, 1'b1, 9);
        n_checks++;
        if (disp_accept !== 1'b0) $display("FAIL rsfull_reject: got %b want 0", disp_accept);
        else n_pass++;
        drive(2, 6, 1'b1, 3, 1'b1, 5);
        n_checks++;
        if ({disp_accept, disp_tag} !== {1'b1, 3'd5})
            $display("FAIL rsfull_mul: got %b/%0d want 1/5", disp_accept, disp_tag);
        else n_pass++;
        tick();
        idle();
        tick();
        n_checks++;
        if ({cdb2_valid, cdb2_tag, cdb2_value, rob_count, commit_valid} !==
            {1'b1, 3'd5, 16'd15, 4'd6, 1'b0})
            $display("FAIL rsfull_mul_exec: got v%b t%0d %0d cnt%0d c%b want v1 t5 15 cnt6 c0",
                     cdb2_valid, cdb2_tag, cdb2_value, rob_count, commit_valid);
        else n_pass++;
    endtask

    task automatic test_rob_full();
        bit got;
        do_reset();
        drive(0, 8, 1'b0, 7, 1'b1, 1);  // head waits on tag 7
        tick();
        for (int i = 1; i <= 6; i++) begin
            drive((i % 2 == 1) ? 2 : 0, i, 1'b1, i, 1'b1, 3);
            tick();
        end
        drive(2, 9, 1'b1, 2, 1'b1, 3);
        tick();
        idle();
        n_checks++;
        if ({rob_full, rob_count} !== {1'b1, 4'd8})
            $display("FAIL robfull_flags: got full %b cnt %0d want 1 8", rob_full, rob_count);
        else n_pass++;
        drive(0, 10, 1'b1, 1, 1'b1, 1);
        n_checks++;
        if (disp_accept !== 1'b0) $display("FAIL robfull_reject: got %b want 0", disp_accept);
        else n_pass++;
        idle();
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (commit_valid) got = 1'b1;
        end
        n_checks++;
        if (!got || {commit_reg, commit_tag, commit_value} !== {4'd8, 3'd0, 16'd7})
            $display("FAIL robfull_head_commit: got seen%b r%0d t%0d %0d want seen1 r8 t0 7",
                     got, commit_reg, commit_tag, commit_value);
        else n_pass++;
        drive(0, 11, 1'b1, 1, 1'b1, 1);
        n_checks++;
        if ({disp_accept, disp_tag, rob_full} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL robfull_wrap: got acc%b tag%0d full%b want acc1 tag0 full0",
                     disp_accept, disp_tag, rob_full);
        else n_pass++;
        tick();
        idle();
    endtask

    task automatic test_div();
        int a_vec[4];
        int b_vec[4];
        logic [15:0] exp;
        a_vec = '{9, 16'h00F0, 1000, 0};
        b_vec = '{0, 16'h0FF0, 7, 5};
        a_vec[3] = int'($urandom_range(0, 65535));
        b_vec[3] = int'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive(3, 2, 1'b1, a_vec[i], 1'b1, b_vec[i]);
            tick();
            idle();
            tick();
            exp = ref_op(3, a_vec[i], b_vec[i]);
            n_checks++;
            if ({cdb2_valid, cdb2_value} !== {1'b1, exp})
                $display("FAIL div_%0d: %0d op3 %0d got v%b %h want v1 %h",
                         i, a_vec[i], b_vec[i], cdb2_valid, cdb2_value, exp);
            else n_pass++;
        end
`ifdef EXWB_DIV_EN
        n_checks++;
        if (ref_op(3, 9, 0) !== 16'hFFFF || a_vec[0] != 9)
            $display("FAIL div_zero_model: got %h want ffff", ref_op(3, 9, 0));
        else n_pass++;
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        for (int op = 4; op < 16; op += 5) begin
            drive(op, 1, 1'b1, 1, 1'b1, 1);
            n_checks++;
            if (disp_accept !== 1'b0) $display("FAIL illegal_op%0d: got %b want 0", op, disp_accept);
            else n_pass++;
            tick();
        end
        idle();
        tick();
        n_checks++;
        if ({rob_count, disp_tag, cdb1_valid, cdb2_valid} !== '0)
            $display("FAIL illegal_state: got cnt%0d tag%0d want 0 0", rob_count, disp_tag);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        drive(0, 1, 1'b0, 7, 1'b1, 1);
        tick();
        drive(2, 2, 1'b1, 2, 1'b1, 2);
        tick();
        drive(0, 3, 1'b0, 7, 1'b1, 3);
        tick();
        idle();
        n_checks++;
        if (rob_count !== 4'd3) $display("FAIL midrst_live: got %0d want 3", rob_count);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({disp_accept, disp_tag, rob_full, rs1_full, rs2_full, rob_count, cdb1_valid,
             cdb1_tag, cdb1_value, cdb2_valid, cdb2_tag, cdb2_value, commit_valid,
             commit_reg, commit_tag, commit_value} !== '0)
            $display("FAIL midrst_outputs: got nonzero outputs after reset (cnt %0d cdb2 %b)",
                     rob_count, cdb2_valid);
        else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (commit_valid || cdb1_valid || cdb2_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midrst_no_commit: got activity %b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t exp_q[$];
        exp_t e;
        int tail;
        int op, idx;
        logic r1, r2;
        int s1, s2, a, b;
        do_reset();
        tail = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 3) != 0) begin
                op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 15))
                                                 : int'($urandom_range(0, 3));
                if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = int'($urandom_range(0, exp_q.size() - 1));
                    r1 = 1'b0; s1 = int'(exp_q[idx].tag); a = int'(exp_q[idx].val);
                end else begin
                    r1 = 1'b1; s1 = int'($urandom_range(0, 65535)); a = s1;
                end
                if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx = int'($urandom_range(0, exp_q.size() - 1));
                    r2 = 1'b0; s2 = int'(exp_q[idx].tag); b = int'(exp_q[idx].val);
                end else begin
                    r2 = 1'b1; s2 = int'($urandom_range(0, 65535)); b = s2;
                end
                drive(op, int'($urandom_range(0, 15)), r1, s1, r2, s2);
                if (op > 3 || exp_q.size() == 8) begin
                    n_checks++;
                    if (disp_accept !== 1'b0)
                        $display("FAIL rand_reject cyc%0d: op %0d live %0d got %b want 0",
                                 cyc, op, exp_q.size(), disp_accept);
                    else n_pass++;
                end
                if (disp_accept === 1'b1) begin
                    n_checks++;
                    if (disp_tag !== 3'(tail))
                        $display("FAIL rand_tag cyc%0d: got %0d want %0d", cyc, disp_tag, tail);
                    else n_pass++;
                    e.dest = disp_dest;
                    e.tag  = 3'(tail);
                    e.val  = ref_op(op, a, b);
                    exp_q.push_back(e);
                    tail = (tail + 1) % 8;
                end
            end
            tick();
            idle();
            if (commit_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_commit cyc%0d: got unexpected commit tag %0d", cyc,
                             commit_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({commit_reg, commit_tag, commit_value} !== {e.dest, e.tag, e.val})
                        $display("FAIL rand_commit cyc%0d: got r%0d t%0d %h want r%0d t%0d %h",
                                 cyc, commit_reg, commit_tag, commit_value, e.dest, e.tag,
                                 e.val);
                    else n_pass++;
                end
            end
        end
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            tick();
            if (commit_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({commit_reg, commit_tag, commit_value} !== {e.dest, e.tag, e.val})
                    $display("FAIL rand_drain: got r%0d t%0d %h want r%0d t%0d %h",
                             commit_reg, commit_tag, commit_value, e.dest, e.tag, e.val);
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if (exp_q.size() != 0 || rob_count !== 4'd0)
            $display("FAIL rand_drain_done: got pending %0d cnt %0d want 0 0",
                     exp_q.size(), rob_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_independent_add();
        test_dependency();
        test_rs_full();
        test_rob_full();
        test_div();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
